// File: rtl/corescore_reset_seq.sv
// Staggered reset fan-out: stretches the generator reset, then releases NUM_STAGES groups GAP cycles apart; debounced button restarts it.
// Latency: o_rst[0] falls STRETCH cycles after i_rst falls, o_ready one cycle after the last group; button adds 2+DEBOUNCE cycles.
// Backpressure: none; free-running sequencer, all outputs registered.
module corescore_reset_seq #(
    parameter int STRETCH    = 16,
    parameter int GAP        = 8,
    parameter int NUM_STAGES = 4,
    parameter int DEBOUNCE   = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_btn,
    output logic [NUM_STAGES-1:0] o_rst,
    output logic                  o_ready
);

    localparam int MAX_A = (STRETCH > GAP) ? STRETCH : GAP;
    localparam int MAX_C = (MAX_A > DEBOUNCE) ? MAX_A : DEBOUNCE;
    localparam int CW    = $clog2(MAX_C + 1);
    localparam int SW    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_STRETCH,
        ST_STAGGER,
        ST_RUN
    } state_t;

    state_t                  state, state_nxt;
    logic [CW-1:0]           cnt, cnt_nxt;
    logic [SW-1:0]           stage, stage_nxt;
    logic [NUM_STAGES-1:0]   rst_nxt;
    logic                    ready_nxt;

    logic                    btn_meta;
    logic                    btn_sync;
    logic [CW-1:0]           deb_cnt;
    logic                    deb_armed;
    logic                    btn_evt;

    // Button path: two-flop synchronizer, saturating debounce counter, one-shot event.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            btn_meta  <= 1'b0;
            btn_sync  <= 1'b0;
            deb_cnt   <= '0;
            deb_armed <= 1'b1;
            btn_evt   <= 1'b0;
        end else begin
            btn_meta <= i_btn;
            btn_sync <= btn_meta;
            btn_evt  <= 1'b0;
            if (!btn_sync) begin
                deb_cnt   <= '0;
                deb_armed <= 1'b1;
            end else begin
                if (deb_cnt != CW'(DEBOUNCE - 1)) begin
                    deb_cnt <= deb_cnt + CW'(1);
                end
                if (deb_cnt == CW'(DEBOUNCE - 1) && deb_armed) begin
                    btn_evt   <= 1'b1;
                    deb_armed <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_HOLD;
            cnt     <= '0;
            stage   <= '0;
            o_rst   <= '1;
            o_ready <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            stage   <= stage_nxt;
            o_rst   <= rst_nxt;
            o_ready <= ready_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stage_nxt = stage;
        rst_nxt   = o_rst;
        ready_nxt = o_ready;
        case (state)
            ST_HOLD: begin
                rst_nxt   = '1;
                ready_nxt = 1'b0;
                cnt_nxt   = '0;
                stage_nxt = '0;
                state_nxt = ST_STRETCH;
            end
            ST_STRETCH: begin
                if (btn_evt) begin
                    state_nxt = ST_HOLD;
                    rst_nxt   = '1;
                    ready_nxt = 1'b0;
                    cnt_nxt   = '0;
                    stage_nxt = '0;
                end else if (cnt == CW'(STRETCH - 1)) begin
                    rst_nxt[0] = 1'b0;
                    stage_nxt  = SW'(1);
                    cnt_nxt    = '0;
                    state_nxt  = (NUM_STAGES == 1) ? ST_RUN : ST_STAGGER;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            ST_STAGGER: begin
                if (btn_evt) begin
                    state_nxt = ST_HOLD;
                    rst_nxt   = '1;
                    ready_nxt = 1'b0;
                    cnt_nxt   = '0;
                    stage_nxt = '0;
                end else if (cnt == CW'(GAP - 1)) begin
                    rst_nxt[stage] = 1'b0;
                    cnt_nxt        = '0;
                    if (stage == SW'(NUM_STAGES - 1)) begin
                        state_nxt = ST_RUN;
                    end else begin
                        stage_nxt = stage + SW'(1);
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            ST_RUN: begin
                if (btn_evt) begin
                    state_nxt = ST_HOLD;
                    rst_nxt   = '1;
                    ready_nxt = 1'b0;
                    cnt_nxt   = '0;
                    stage_nxt = '0;
                end else begin
                    ready_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_HOLD;
                rst_nxt   = '1;
                ready_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_corescore_reset_seq.sv
// Bench for corescore_reset_seq: timeline tables, hand-written corner sequences and
// a randomized button/reset run checked every cycle against a release-timeline model.
module tb_corescore_reset_seq;

    localparam int S = 16;
    localparam int G = 8;
    localparam int N = 4;
    localparam int D = 1024;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_btn = 1'b0;
    logic [N-1:0] o_rst;
    logic         o_ready;

    logic         rst2 = 1'b1;
    logic         btn2 = 1'b0;
    logic [0:0]   o_rst2;
    logic         o_ready2;

    always #5 i_clk = ~i_clk;

    corescore_reset_seq #(.STRETCH(S), .GAP(G), .NUM_STAGES(N), .DEBOUNCE(D)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_btn(i_btn), .o_rst(o_rst), .o_ready(o_ready)
    );

    corescore_reset_seq #(.STRETCH(3), .GAP(2), .NUM_STAGES(1), .DEBOUNCE(4)) dut2 (
        .i_clk(i_clk), .i_rst(rst2), .i_btn(btn2), .o_rst(o_rst2), .o_ready(o_ready2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: while active, every output is a pure function of the cycle distance from E0.
    int cyc = 0;
    bit m_act = 0;
    int m_e0 = 0;
    bit m_evt = 0;
    int m_run = 0;
    bit m_dly [2] = '{0, 0};
    int dut_restarts = 0;
    bit prev_rst0 = 1'b1;

    function automatic logic [N-1:0] exp_rst();
        logic [N-1:0] r;
        for (int k = 0; k < N; k++) r[k] = !(m_act && cyc >= m_e0 + S + k * G);
        return r;
    endfunction

    function automatic logic exp_ready();
        return m_act && cyc >= m_e0 + S + (N - 1) * G + 1;
    endfunction

    task automatic model_step();
        bit lvl;
        bit evt_next;
        lvl = m_dly[1];
        if (i_rst) begin
            m_act = 0;
            m_evt = 0;
            m_run = 0;
            m_dly[0] = 0;
            m_dly[1] = 0;
        end else begin
            evt_next = 0;
            if (lvl) begin
                m_run++;
                if (m_run == D) evt_next = 1;
            end else begin
                m_run = 0;
            end
            if (!m_act) begin
                m_act = 1;
                m_e0 = cyc;
            end else if (m_evt) begin
                m_act = 0;
            end
            m_evt = evt_next;
            m_dly[1] = m_dly[0];
            m_dly[0] = i_btn;
        end
    endtask

    always @(posedge i_clk) begin
        bit rst_at_edge;
        rst_at_edge = i_rst;
        cyc++;
        model_step();
        #1;
        check("model o_rst", 32'(o_rst), 32'(exp_rst()));
        check("model o_ready", 32'(o_ready), 32'(exp_ready()));
        if (!prev_rst0 && o_rst[0] && !rst_at_edge) dut_restarts++;
        prev_rst0 = o_rst[0];
    end

    typedef struct {
        int           off;
        logic [N-1:0] rst;
        logic         rdy;
    } vec_t;

    vec_t tbl [11];

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #2;
    endtask

    // Assumes the caller stands just after E0.
    task automatic apply_table(input string tag);
        int cur;
        cur = 0;
        for (int i = 0; i < 11; i++) begin
            tick(tbl[i].off - cur);
            cur = tbl[i].off;
            check($sformatf("%s E0+%0d o_rst", tag, cur), 32'(o_rst), 32'(tbl[i].rst));
            check($sformatf("%s E0+%0d o_ready", tag, cur), 32'(o_ready), 32'(tbl[i].rdy));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int glitch [3];
        tbl[0]  = '{0,  4'b1111, 1'b0};
        tbl[1]  = '{15, 4'b1111, 1'b0};
        tbl[2]  = '{16, 4'b1110, 1'b0};
        tbl[3]  = '{23, 4'b1110, 1'b0};
        tbl[4]  = '{24, 4'b1100, 1'b0};
        tbl[5]  = '{31, 4'b1100, 1'b0};
        tbl[6]  = '{32, 4'b1000, 1'b0};
        tbl[7]  = '{39, 4'b1000, 1'b0};
        tbl[8]  = '{40, 4'b0000, 1'b0};
        tbl[9]  = '{41, 4'b0000, 1'b1};
        tbl[10] = '{60, 4'b0000, 1'b1};
        glitch = '{1, 500, 1022};

        // Power-on
        repeat (10) @(negedge i_clk);
        check("reset o_rst", 32'(o_rst), 32'hF);
        check("reset o_ready", 32'(o_ready), 32'h0);
        @(negedge i_clk) i_rst = 1'b0;
        tick(1);
        apply_table("poweron");

        // Reset re-asserted after groups 0 and 1 are out
        @(negedge i_clk) i_rst = 1'b1;
        tick(3);
        @(negedge i_clk) i_rst = 1'b0;
        tick(1);
        tick(27);
        check("midrst pre o_rst", 32'(o_rst), 32'hC);
        @(negedge i_clk) i_rst = 1'b1;
        tick(1);
        check("midrst o_rst", 32'(o_rst), 32'hF);
        check("midrst o_ready", 32'(o_ready), 32'h0);
        @(negedge i_clk) i_rst = 1'b0;
        tick(1);
        apply_table("rerun");

        // Short presses must be rejected
        r0 = dut_restarts;
        foreach (glitch[i]) begin
            @(negedge i_clk) i_btn = 1'b1;
            repeat (glitch[i]) @(negedge i_clk);
            i_btn = 1'b0;
            repeat (1100) @(negedge i_clk);
            check($sformatf("glitch%0d o_rst", glitch[i]), 32'(o_rst), 32'h0);
            check($sformatf("glitch%0d o_ready", glitch[i]), 32'(o_ready), 32'h1);
        end
        check("glitch restarts", 32'(dut_restarts), 32'(r0));

        // Long hold: exactly one restart, 2+DEBOUNCE cycles after the press
        @(negedge i_clk) i_btn = 1'b1;
        tick(1026);
        check("hold before o_ready", 32'(o_ready), 32'h1);
        tick(1);
        check("hold restart o_rst", 32'(o_rst), 32'hF);
        check("hold restart o_ready", 32'(o_ready), 32'h0);
        repeat (5000 - 1027) @(negedge i_clk);
        i_btn = 1'b0;
        check("hold restarts", 32'(dut_restarts), 32'(r0 + 1));
        check("hold end o_ready", 32'(o_ready), 32'h1);
        @(negedge i_clk) i_btn = 1'b1;
        repeat (1100) @(negedge i_clk);
        i_btn = 1'b0;
        repeat (200) @(negedge i_clk);
        check("repress restarts", 32'(dut_restarts), 32'(r0 + 2));

        // Reset held while the button toggles slowly
        r0 = dut_restarts;
        @(negedge i_clk) i_rst = 1'b1;
        for (int p = 0; p < 3; p++) begin
            i_btn = 1'b1;
            repeat (1000) @(negedge i_clk);
            check("rstbtn hi o_rst", 32'(o_rst), 32'hF);
            i_btn = 1'b0;
            repeat (1000) @(negedge i_clk);
            check("rstbtn lo o_ready", 32'(o_ready), 32'h0);
        end
        i_rst = 1'b0;
        repeat (1300) @(negedge i_clk);
        check("rstbtn release o_ready", 32'(o_ready), 32'h1);
        check("rstbtn restarts", 32'(dut_restarts), 32'(r0));

        // Randomized button presses and reset pulses, checked by the model each cycle
        for (int it = 0; it < 14; it++) begin
            int act;
            int len;
            act = $urandom_range(0, 9);
            if (act == 0) begin
                i_rst = 1'b1;
                repeat ($urandom_range(1, 5)) @(negedge i_clk);
                i_rst = 1'b0;
            end else begin
                if (act < 4) len = D - 2 + $urandom_range(0, 4);
                else len = $urandom_range(1, 1300);
                i_btn = 1'b1;
                repeat (len) @(negedge i_clk);
                i_btn = 1'b0;
            end
            repeat ($urandom_range(10, 400)) @(negedge i_clk);
        end
        repeat (100) @(negedge i_clk);

        // Single group, STRETCH=3, DEBOUNCE=4
        check("n1 reset o_rst", 32'(o_rst2), 32'h1);
        @(negedge i_clk) rst2 = 1'b0;
        tick(1);
        tick(2);
        check("n1 E0+2 o_rst", 32'(o_rst2), 32'h1);
        tick(1);
        check("n1 E0+3 o_rst", 32'(o_rst2), 32'h0);
        check("n1 E0+3 o_ready", 32'(o_ready2), 32'h0);
        tick(1);
        check("n1 E0+4 o_ready", 32'(o_ready2), 32'h1);
        @(negedge i_clk) btn2 = 1'b1;
        tick(6);
        check("n1 btn pre o_rst", 32'(o_rst2), 32'h0);
        tick(1);
        check("n1 btn restart o_rst", 32'(o_rst2), 32'h1);
        check("n1 btn restart o_ready", 32'(o_ready2), 32'h0);
        tick(4);
        check("n1 new E0+3 o_rst", 32'(o_rst2), 32'h0);
        check("n1 new E0+3 o_ready", 32'(o_ready2), 32'h0);
        tick(1);
        check("n1 new E0+4 o_ready", 32'(o_ready2), 32'h1);
        tick(30);
        check("n1 held once o_rst", 32'(o_rst2), 32'h0);
        check("n1 held once o_ready", 32'(o_ready2), 32'h1);
        @(negedge i_clk) btn2 = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
